ddr_app_arbiter: RTL and testbench

DDR_APP_ARBITER -- requirements
Module: ddr_app_arbiter

---
 rtl/ddr_dispatch_pkg.sv | 18 +
 rtl/ddr_wr_handshake.sv | 37 +++
 rtl/ddr_app_arbiter.sv | 127 ++++++++++++
 tb/tb_ddr_app_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_dispatch_pkg.sv
// Shared types and command constants for the DDR application-port arbiter.
package ddr_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } side_t;

    localparam logic [2:0] READ_CMD  = 3'b001;
    localparam logic [2:0] WRITE_CMD = 3'b000;

endpackage

// File: rtl/ddr_wr_handshake.sv
// Tracks independent command/data acceptance of one write and pulses wr_ready
// in the cycle the later of the two is taken by the controller.
module ddr_wr_handshake (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic app_rdy,
    input  logic app_wdf_rdy,
    output logic cmd_en,
    output logic data_en,
    output logic wr_ready
);

    logic cmd_done;
    logic data_done;
    logic cmd_acc;
    logic data_acc;

    assign cmd_en   = active & ~cmd_done;
    assign data_en  = active & ~data_done;
    assign cmd_acc  = cmd_en & app_rdy;
    assign data_acc = data_en & app_wdf_rdy;
    // Completion counts a flag set earlier or an acceptance happening now.
    assign wr_ready = active & (cmd_done | cmd_acc) & (data_done | data_acc);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || wr_ready || !active) begin
            cmd_done  <= 1'b0;
            data_done <= 1'b0;
        end else begin
            if (cmd_acc)  cmd_done  <= 1'b1;
            if (data_acc) data_done <= 1'b1;
        end
    end

endmodule

// File: rtl/ddr_app_arbiter.sv
// Two-requester (read/write) arbiter onto a DDR controller application port,
// with round-robin tie-break and a burst limit while the other side waits.
module ddr_app_arbiter
    import ddr_dispatch_pkg::*;
#(
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 128,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    state_t           state, state_next;
    side_t            last_grant;
    logic [CNT_W-1:0] burst_cnt;
    logic             rd_active, wr_active;
    logic             wr_cmd_en, wr_data_en;
    logic             done, cur_valid, oth_valid;
    state_t           oth_state;

    // Reset gates the enables so nothing is accepted in a cycle being abandoned.
    assign rd_active = (state == ST_RD) & rd_valid & ~reset;
    assign wr_active = (state == ST_WR) & wr_valid & ~reset;
    assign rd_ready  = rd_active & app_rdy;
    assign done      = rd_ready | wr_ready;
    assign busy      = (state != ST_IDLE);

    ddr_wr_handshake u_wr_handshake (
        .clk         (clk),
        .reset       (reset),
        .active      (wr_active),
        .app_rdy     (app_rdy),
        .app_wdf_rdy (app_wdf_rdy),
        .cmd_en      (wr_cmd_en),
        .data_en     (wr_data_en),
        .wr_ready    (wr_ready)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        app_en       = 1'b0;
        app_cmd      = WRITE_CMD;
        app_addr     = '0;
        app_wdf_data = '0;
        app_wdf_wren = 1'b0;
        if (rd_active) begin
            app_en   = 1'b1;
            app_cmd  = READ_CMD;
            app_addr = rd_addr;
        end else if (wr_active) begin
            app_en       = wr_cmd_en;
            app_addr     = wr_addr;
            app_wdf_data = wr_data;
            app_wdf_wren = wr_data_en;
        end
    end

    assign app_wdf_end = app_wdf_wren;

    always_comb begin
        state_next = state;
        cur_valid  = (state == ST_RD) ? rd_valid : wr_valid;
        oth_valid  = (state == ST_RD) ? wr_valid : rd_valid;
        oth_state  = (state == ST_RD) ? ST_WR : ST_RD;
        case (state)
            ST_IDLE: begin
                if (rd_valid && wr_valid)
                    state_next = (last_grant == WR) ? ST_RD : ST_WR;
                else if (rd_valid)
                    state_next = ST_RD;
                else if (wr_valid)
                    state_next = ST_WR;
            end
            ST_RD, ST_WR: begin
                if (done) begin
                    if (oth_valid && burst_cnt == CNT_MAX) state_next = oth_state;
                    else if (cur_valid)                    state_next = state;
                    else if (oth_valid)                    state_next = oth_state;
                    else                                   state_next = ST_IDLE;
                end else if (!cur_valid) begin
                    // Served side has nothing further queued: hand over or go idle.
                    state_next = oth_valid ? oth_state : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            burst_cnt  <= '0;
            last_grant <= WR;
        end else begin
            state <= state_next;
            if (done)
                last_grant <= (state == ST_RD) ? RD : WR;
            if (state_next == ST_IDLE)
                burst_cnt <= '0;
            else if (state_next != state)
                burst_cnt <= CNT_W'(1);
            else if (done && burst_cnt != CNT_MAX)
                burst_cnt <= burst_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ddr_app_arbiter.sv
// Directed self-checking bench for ddr_app_arbiter.
module tb_ddr_app_arbiter;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy;
    logic [DATA_W-1:0] app_wdf_data;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_wdf_rdy;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    ddr_app_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_valid     (rd_valid),
        .rd_addr      (rd_addr),
        .rd_ready     (rd_ready),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .app_addr     (app_addr),
        .app_cmd      (app_cmd),
        .app_en       (app_en),
        .app_rdy      (app_rdy),
        .app_wdf_data (app_wdf_data),
        .app_wdf_wren (app_wdf_wren),
        .app_wdf_end  (app_wdf_end),
        .app_wdf_rdy  (app_wdf_rdy),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        reset       = 1'b1;
        rd_valid    = 1'b0;
        wr_valid    = 1'b0;
        app_rdy     = 1'b0;
        app_wdf_rdy = 1'b0;
        rd_addr     = '0;
        wr_addr     = '0;
        wr_data     = '0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    localparam logic [DATA_W-1:0] WDATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FACE_B00C;

    initial begin
        int pulses;
        bit exp_rd;

        do_reset();
        #1;
        check("reset_busy", busy, 0);
        check("reset_app_en", app_en, 0);
        check("reset_rd_ready", rd_ready, 0);
        check("reset_wr_ready", wr_ready, 0);
        check("reset_app_addr", app_addr, 0);

        // Single read.
        cyc();
        rd_valid = 1'b1; rd_addr = 27'h0000100; app_rdy = 1'b1;
        #1;
        check("rd1_idle_app_en", app_en, 0);
        cyc(); #1;
        check("rd1_app_en", app_en, 1);
        check("rd1_cmd", app_cmd, 3'b001);
        check("rd1_addr", app_addr, 27'h0000100);
        check("rd1_rd_ready", rd_ready, 1);
        check("rd1_busy", busy, 1);
        cyc();
        rd_valid = 1'b0; app_rdy = 1'b0;
        #1;
        check("rd1_after_rd_ready", rd_ready, 0);
        check("rd1_after_app_en", app_en, 0);
        cyc(); #1;
        check("rd1_back_idle", busy, 0);

        // Single write, data at cycle 2, command at cycle 4.
        do_reset();
        cyc();
        wr_valid = 1'b1; wr_addr = 27'h0000200; wr_data = WDATA;
        #1;
        check("wr_c0_wren", app_wdf_wren, 0);
        cyc(); #1;
        check("wr_c1_app_en", app_en, 1);
        check("wr_c1_wren", app_wdf_wren, 1);
        check("wr_c1_wr_ready", wr_ready, 0);
        cyc();
        app_wdf_rdy = 1'b1;
        #1;
        check("wr_c2_wren", app_wdf_wren, 1);
        check("wr_c2_wdf_end", app_wdf_end, 1);
        check("wr_c2_wr_ready", wr_ready, 0);
        cyc();
        app_wdf_rdy = 1'b0;
        #1;
        check("wr_c3_wren_dropped", app_wdf_wren, 0);
        check("wr_c3_app_en_held", app_en, 1);
        check("wr_c3_wr_ready", wr_ready, 0);
        cyc();
        app_rdy = 1'b1;
        #1;
        check("wr_c4_wr_ready", wr_ready, 1);
        check("wr_c4_cmd", app_cmd, 3'b000);
        check("wr_c4_addr", app_addr, 27'h0000200);
        check("wr_c4_data", app_wdf_data, WDATA);
        cyc();
        wr_valid = 1'b0; app_rdy = 1'b0;
        #1;
        check("wr_c5_wr_ready", wr_ready, 0);
        cyc(); #1;
        check("wr_c6_idle", busy, 0);

        // Both requesters saturated: alternating bursts of eight, reads first.
        cyc();
        reset = 1'b1; rd_valid = 1'b1; wr_valid = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        rd_addr = 27'h0000040; wr_addr = 27'h0000080;
        #1;
        check("burst_reset_rd_ready", rd_ready, 0);
        check("burst_reset_wr_ready", wr_ready, 0);
        cyc();
        reset = 1'b0;
        #1;
        check("burst_idle_app_en", app_en, 0);
        for (int k = 0; k < 32; k++) begin
            cyc(); #1;
            exp_rd = ((k / 8) % 2) == 0;
            check($sformatf("burst_%0d_rd_ready", k), rd_ready, exp_rd);
            check($sformatf("burst_%0d_wr_ready", k), wr_ready, !exp_rd);
            check($sformatf("burst_%0d_cmd", k), app_cmd, exp_rd ? 3'b001 : 3'b000);
        end

        // Read stalled by the controller for twenty cycles.
        do_reset();
        cyc();
        rd_valid = 1'b1; rd_addr = 27'h3A5A5A5;
        cyc();
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("stall_%0d_app_en", i), app_en, 1);
            check($sformatf("stall_%0d_addr", i), app_addr, 27'h3A5A5A5);
            check($sformatf("stall_%0d_rd_ready", i), rd_ready, 0);
            cyc();
        end
        app_rdy = 1'b1;
        #1;
        check("stall_release_rd_ready", rd_ready, 1);
        cyc();
        rd_valid = 1'b0; app_rdy = 1'b0;

        // Reset after the data beat but before the command.
        do_reset();
        cyc();
        wr_valid = 1'b1; wr_addr = 27'h0000300; wr_data = WDATA; app_wdf_rdy = 1'b1;
        #1;
        check("abort_idle_busy", busy, 0);
        cyc(); #1;
        check("abort_data_beat", app_wdf_wren, 1);
        cyc();
        app_wdf_rdy = 1'b0;
        #1;
        check("abort_wren_done", app_wdf_wren, 0);
        check("abort_app_en_pending", app_en, 1);
        cyc();
        reset = 1'b1;
        #1;
        check("abort_reset_wr_ready", wr_ready, 0);
        cyc();
        reset = 1'b0;
        #1;
        check("abort_post_busy", busy, 0);
        check("abort_post_app_en", app_en, 0);
        check("abort_post_wren", app_wdf_wren, 0);
        check("abort_post_addr", app_addr, 0);
        check("abort_post_data", app_wdf_data, 0);
        check("abort_post_wr_ready", wr_ready, 0);
        cyc(); #1;
        check("abort_retry_wren", app_wdf_wren, 1);
        check("abort_retry_app_en", app_en, 1);

        // Command and data accepted in the same cycle.
        do_reset();
        cyc();
        wr_valid = 1'b1; wr_addr = 27'h0000400; wr_data = WDATA; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 1) wr_valid = 1'b0;
            #1;
            if (i == 0) check("same_cycle_wr_ready", wr_ready, 1);
            pulses += int'(wr_ready);
        end
        check("same_cycle_pulse_count", pulses, 1);
        check("same_cycle_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
